// File: rtl/nios_system2_cpu_0_oci_dct_packer_pkg.sv
// Shared constants for the OCI DCT trace path: code widths, frame depth,
// frame field offsets and the output-register state type.
package oci_trace_pkg;

  localparam int ENTRY_W = 2;
  localparam int DEPTH   = 15;
  localparam int CNT_W   = 4;
  localparam int BUF_W   = DEPTH * ENTRY_W;
  localparam int TAG_W   = 2;
  localparam int TW_W    = TAG_W + CNT_W + BUF_W;

  localparam logic [TAG_W-1:0] TAG = 2'b10;

  localparam logic [ENTRY_W-1:0] DCT_NT  = 2'b00;
  localparam logic [ENTRY_W-1:0] DCT_TK  = 2'b01;
  localparam logic [ENTRY_W-1:0] DCT_EXC = 2'b10;
  localparam logic [ENTRY_W-1:0] DCT_OTH = 2'b11;

  localparam int BUF_LSB = 0;
  localparam int CNT_LSB = BUF_W;
  localparam int TAG_LSB = BUF_W + CNT_W;

  typedef enum logic {
    TW_EMPTY = 1'b0,
    TW_PEND  = 1'b1
  } tw_state_t;

  function automatic logic [TW_W-1:0] pack_frame(input logic [CNT_W-1:0] cnt,
                                                 input logic [BUF_W-1:0] codes);
    return {TAG, cnt, codes};
  endfunction

endpackage

// File: rtl/nios_system2_cpu_0_oci_dct_packer_if.sv
// Valid/ready trace-word bus between the DCT packer and trace memory.
interface nios_system2_cpu_0_oci_dct_packer_if;
  import oci_trace_pkg::*;

  logic            tw_valid;
  logic            tw_ready;
  logic [TW_W-1:0] tw_data;

  modport master (output tw_valid, output tw_data, input tw_ready);
  modport slave  (input tw_valid, input tw_data, output tw_ready);

endinterface

// File: rtl/nios_system2_cpu_0_oci_tw_reg.sv
// One-deep valid/ready holding register for emitted trace words.
// state | meaning
// EMPTY | no word held, tw_valid=0
// PEND  | word held stable in data_o until ready_i
module nios_system2_cpu_0_oci_tw_reg
  import oci_trace_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [TW_W-1:0] data_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [TW_W-1:0] data_o,
  output logic            free_o
);

  tw_state_t       state_q, state_d;
  logic [TW_W-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TW_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) data_d = data_i;
    unique case (state_q)
      TW_EMPTY: if (load_i) state_d = TW_PEND;
      TW_PEND:  if (ready_i) state_d = load_i ? TW_PEND : TW_EMPTY;
      default:  state_d = TW_EMPTY;
    endcase
  end

  always_comb begin
    valid_o = (state_q == TW_PEND);
    data_o  = data_q;
    free_o  = (state_q == TW_EMPTY) || ready_i;
  end

endmodule

// File: rtl/nios_system2_cpu_0_oci_dct_packer.sv
// DCT trace writer: packs 2-bit codes into a 15-entry buffer and hands full or
// flushed frames to the trace-word holding register.
module nios_system2_cpu_0_oci_dct_packer
  import oci_trace_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                trc_on,
  input  logic                dct_valid,
  input  logic [ENTRY_W-1:0]  dct_code,
  input  logic                flush,
  nios_system2_cpu_0_oci_dct_packer_if.master tw,
  output logic [BUF_W-1:0]    dct_buffer,
  output logic [CNT_W-1:0]    dct_count,
  output logic                overflow
);

  logic [BUF_W-1:0] buf_q, buf_d, mrg_buf;
  logic [CNT_W-1:0] cnt_q, cnt_d, mrg_cnt;
  logic             req_q, req_d;
  logic             trc_q;
  logic             ovf_q, ovf_d;
  logic             in_code, trc_fall, full, accept, out_free, xfer;
  logic             tw_valid_w;
  logic [TW_W-1:0]  frame, tw_data_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q <= '0;
      cnt_q <= '0;
      req_q <= 1'b0;
      trc_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      trc_q <= trc_on;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    in_code  = trc_on & dct_valid;
    trc_fall = trc_q & ~trc_on;
    full     = (cnt_q == CNT_W'(DEPTH));
    accept   = in_code & (~full | out_free);
    mrg_buf  = buf_q;
    mrg_cnt  = cnt_q;
    if (accept && !full) begin
      mrg_buf = buf_q | (BUF_W'(dct_code) << (ENTRY_W * cnt_q));
      mrg_cnt = cnt_q + CNT_W'(1);
    end
    xfer  = out_free & ((mrg_cnt == CNT_W'(DEPTH)) |
                        ((flush | trc_fall | req_q) & (mrg_cnt != '0)));
    frame = pack_frame(mrg_cnt, mrg_buf);
    buf_d = mrg_buf;
    cnt_d = mrg_cnt;
    req_d = req_q | ((flush | trc_fall) & (mrg_cnt != '0));
    if (xfer) begin
      buf_d = '0;
      cnt_d = '0;
      req_d = 1'b0;
      // A stalled full frame drains this cycle, so the new code starts the next frame.
      if (full && accept) begin
        buf_d = BUF_W'(dct_code);
        cnt_d = CNT_W'(1);
      end
    end
    ovf_d = ovf_q | (in_code & ~accept);
  end

  nios_system2_cpu_0_oci_tw_reg u_tw_reg (
    .clk     (clk),
    .rst_n   (reset_n),
    .load_i  (xfer),
    .data_i  (frame),
    .ready_i (tw.tw_ready),
    .valid_o (tw_valid_w),
    .data_o  (tw_data_w),
    .free_o  (out_free)
  );

  assign tw.tw_valid = tw_valid_w;
  assign tw.tw_data  = tw_data_w;
  assign dct_buffer  = buf_q;
  assign dct_count   = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_nios_system2_cpu_0_oci_dct_packer.sv
// Directed bench for the DCT packer: per-cycle comparison against a queue-based
// model plus literal frame expectations for each scenario.
module tb_nios_system2_cpu_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trc_on, dct_valid, flush, tw_ready;
  logic [1:0]  dct_code;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  nios_system2_cpu_0_oci_dct_packer_if tw();
  assign tw.tw_ready = tw_ready;

  nios_system2_cpu_0_oci_dct_packer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .trc_on     (trc_on),
    .dct_valid  (dct_valid),
    .dct_code   (dct_code),
    .flush      (flush),
    .tw         (tw),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending codes as a queue, held word as valid/data pair.
  bit [1:0]    m_codes[$];
  bit          m_valid, m_req, m_trc_prev, m_ovf;
  logic [35:0] m_data;
  logic [35:0] dut_words[$];

  function automatic logic [29:0] pack(input int n);
    logic [29:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r |= 30'(m_codes[i]) << (2 * i);
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_codes.delete();
      m_valid = 0; m_req = 0; m_trc_prev = 0; m_ovf = 0; m_data = '0;
    end else begin
      bit free, fall, want;
      int n;
      free = !m_valid || tw_ready;
      fall = m_trc_prev && !trc_on;
      if (m_valid && tw_ready) m_valid = 0;
      if (trc_on && dct_valid) begin
        if (m_codes.size() == 15 && !free) m_ovf = 1;
        else m_codes.push_back(dct_code);
      end
      want = (m_codes.size() >= 15) || ((flush || fall || m_req) && m_codes.size() > 0);
      if (want && free) begin
        n = (m_codes.size() > 15) ? 15 : m_codes.size();
        m_data  = {2'b10, 4'(n), pack(n)};
        m_valid = 1;
        m_req   = 0;
        for (int i = 0; i < n; i++) void'(m_codes.pop_front());
      end else if ((flush || fall) && m_codes.size() > 0) begin
        m_req = 1;
      end
      m_trc_prev = trc_on;
    end
  end

  always @(posedge clk)
    if (reset_n && tw.tw_valid && tw_ready) dut_words.push_back(tw.tw_data);

  always @(negedge clk) begin
    if (reset_n) begin
      chk("cyc_tw_valid", 36'(tw.tw_valid), 36'(m_valid));
      if (m_valid) chk("cyc_tw_data", tw.tw_data, m_data);
      chk("cyc_dct_buffer", 36'(dct_buffer), 36'(pack(m_codes.size())));
      chk("cyc_dct_count", 36'(dct_count), 36'(m_codes.size()));
      chk("cyc_overflow", 36'(overflow), 36'(m_ovf));
    end
  end

  task automatic cyc(input logic v, input logic [1:0] c, input logic f);
    dct_valid = v; dct_code = c; flush = f;
    @(negedge clk);
    dct_valid = 0; flush = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 2'b00, 0);
  endtask

  int base;

  initial begin
    reset_n = 0; trc_on = 0; dct_valid = 0; dct_code = 0; flush = 0; tw_ready = 1;
    repeat (3) @(negedge clk);
    reset_n = 1;
    chk("rst_tw_valid", 36'(tw.tw_valid), 36'h0);
    chk("rst_tw_data", tw.tw_data, 36'h0);
    chk("rst_buffer", 36'(dct_buffer), 36'h0);
    chk("rst_count", 36'(dct_count), 36'h0);
    chk("rst_overflow", 36'(overflow), 36'h0);

    // 1: full frame of taken codes, one-cycle latency
    trc_on = 1;
    base = dut_words.size();
    for (int i = 0; i < 15; i++) cyc(1, 2'b01, 0);
    chk("t1_valid", 36'(tw.tw_valid), 36'h1);
    chk("t1_data", tw.tw_data, {2'b10, 4'hF, 30'h15555555});
    chk("t1_count", 36'(dct_count), 36'h0);
    idle(3);
    chk("t1_nwords", 36'(dut_words.size() - base), 36'd1);

    // 2: partial frame via flush, second flush is a no-op
    base = dut_words.size();
    cyc(1, 2'b01, 0); cyc(1, 2'b10, 0); cyc(1, 2'b11, 0);
    cyc(0, 2'b00, 1);
    idle(3);
    cyc(0, 2'b00, 1);
    idle(3);
    chk("t2_nwords", 36'(dut_words.size() - base), 36'd1);
    if (dut_words.size() > base) chk("t2_data", dut_words[base], {2'b10, 4'h3, 30'h39});

    // 3: stall with tw_ready low, drop the 31st code
    base = dut_words.size();
    tw_ready = 0;
    for (int i = 0; i < 30; i++) cyc(1, 2'(i % 4), 0);
    chk("t3_valid", 36'(tw.tw_valid), 36'h1);
    chk("t3_count", 36'(dct_count), 36'd15);
    chk("t3_ovf_before", 36'(overflow), 36'h0);
    cyc(1, 2'b10, 0);
    chk("t3_ovf_after", 36'(overflow), 36'h1);
    chk("t3_count_sat", 36'(dct_count), 36'd15);
    tw_ready = 1;
    idle(4);
    chk("t3_nwords", 36'(dut_words.size() - base), 36'd2);
    if (dut_words.size() > base + 1) begin
      chk("t3_word0", dut_words[base], {2'b10, 4'hF, 30'h24E4E4E4});
      chk("t3_word1", dut_words[base + 1], {2'b10, 4'hF, 30'h13939393});
    end

    // 4: flush coincident with the 15th code
    base = dut_words.size();
    for (int i = 0; i < 14; i++) cyc(1, 2'b11, 0);
    cyc(1, 2'b11, 1);
    idle(4);
    chk("t4_nwords", 36'(dut_words.size() - base), 36'd1);
    if (dut_words.size() > base) chk("t4_data", dut_words[base], {2'b10, 4'hF, 30'h3FFFFFFF});

    // 5: trace disable flushes once, codes ignored while off
    base = dut_words.size();
    for (int i = 0; i < 5; i++) cyc(1, 2'b10, 0);
    trc_on = 0;
    idle(1);
    for (int i = 0; i < 3; i++) cyc(1, 2'b01, 0);
    idle(2);
    chk("t5_count", 36'(dct_count), 36'h0);
    chk("t5_nwords", 36'(dut_words.size() - base), 36'd1);
    if (dut_words.size() > base) chk("t5_data", dut_words[base], {2'b10, 4'h5, 30'h2AA});

    // 6: async reset with a word pending and 7 codes buffered
    trc_on = 1; tw_ready = 0;
    for (int i = 0; i < 22; i++) cyc(1, (i < 15) ? 2'b01 : 2'b11, 0);
    chk("t6_pre_valid", 36'(tw.tw_valid), 36'h1);
    chk("t6_pre_count", 36'(dct_count), 36'd7);
    base = dut_words.size();
    #2 reset_n = 0;
    #1;
    chk("t6_valid", 36'(tw.tw_valid), 36'h0);
    chk("t6_data", tw.tw_data, 36'h0);
    chk("t6_buffer", 36'(dct_buffer), 36'h0);
    chk("t6_count", 36'(dct_count), 36'h0);
    chk("t6_ovf", 36'(overflow), 36'h0);
    @(negedge clk); @(negedge clk);
    reset_n = 1; tw_ready = 1;
    idle(4);
    chk("t6_nwords", 36'(dut_words.size() - base), 36'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
